// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the serial magnitude comparator.
//   cmp_state_t  - controller state encoding (IDLE, RUN, DONE)
//   pairs_of()   - number of 2-bit pairs in an operand of a given width
//   cnt_width()  - width of a counter that must hold the value pairs_of(width)
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  function automatic int pairs_of(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2((width / 2) + 1);
  endfunction

endpackage : cmp_pkg

// File: rtl/cmp2_slice.sv
// cmp2_slice: purely combinational 2-bit unsigned magnitude comparator.
// The MSB decides. The LSB decides only when the MSBs are equal.
// Ports:
//   a1, a0  in   bits of operand A (a1 = MSB)
//   b1, b0  in   bits of operand B (b1 = MSB)
//   gt      out  {a1,a0} >  {b1,b0}
//   et      out  {a1,a0} == {b1,b0}
//   lt      out  {a1,a0} <  {b1,b0}
module cmp2_slice (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic gt,
  output logic et,
  output logic lt
);

  logic msb_eq;
  logic lsb_eq;

  assign msb_eq = ~(a1 ^ b1);
  assign lsb_eq = ~(a0 ^ b0);

  assign gt = (a1 & ~b1) | (msb_eq & a0 & ~b0);
  assign lt = (~a1 & b1) | (msb_eq & ~a0 & b0);
  assign et = msb_eq & lsb_eq;

endmodule : cmp2_slice

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: compares two WIDTH-bit unsigned operands
// serially. It consumes one 2-bit pair per cycle, starting with the MSB pair.
// The first pair that differs decides the result.
// Parameters:
//   WIDTH       operand width. It must be even and >= 2.
//   EARLY_EXIT  1: finish on the first differing pair. 0: always scan every pair.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset. It has priority over all other events.
//   in_valid   in   a/b hold a valid operand pair
//   in_ready   out  operands can be accepted (IDLE only)
//   a, b       in   WIDTH-bit unsigned operands
//   out_valid  out  gt/et/lt hold a valid result
//   out_ready  in   consumer accepts the result
//   gt, et, lt out  A>B, A==B, A<B. They read 0 while out_valid is low.
//   busy       out  high in RUN or DONE
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             et,
  output logic             lt,
  output logic             busy
);

  localparam int PAIRS = pairs_of(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
    end
  endgenerate

  cmp_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic             gt_r;
  logic             lt_r;

  logic s_gt;
  logic s_et;
  logic s_lt;

  // The slice always looks at the top pair. The shift registers move the
  // next pair into that position each RUN cycle.
  cmp2_slice u_slice (
    .a1 (sa[WIDTH-1]),
    .a0 (sa[WIDTH-2]),
    .b1 (sb[WIDTH-1]),
    .b0 (sb[WIDTH-2]),
    .gt (s_gt),
    .et (s_et),
    .lt (s_lt)
  );

  logic decided;
  logic nxt_gt;
  logic nxt_lt;
  logic last_pair;
  logic finish;

  // NOTE: every signal gets a default at the top of always_comb. No path can
  // then leave one unassigned, so no latch is inferred.
  always_comb begin
    decided   = 1'b0;
    nxt_gt    = 1'b0;
    nxt_lt    = 1'b0;
    last_pair = 1'b0;
    finish    = 1'b0;

    decided   = gt_r | lt_r;
    // After a pair has differed, the result is frozen. Later pairs cannot override it.
    nxt_gt    = gt_r | (~decided & s_gt);
    nxt_lt    = lt_r | (~decided & s_lt);
    last_pair = (cnt == CNT_W'(1));
    finish    = last_pair | (EARLY_EXIT & ~decided & ~s_et);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from the values it held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand shift registers are cleared as well. They are
      // ordinary flops, not a memory array, so a reset on them costs nothing
      // and gives a defined start state.
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      gt_r      <= 1'b0;
      lt_r      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      et        <= 1'b0;
      lt        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sa       <= a;
            sb       <= b;
            cnt      <= CNT_W'(PAIRS);
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          gt_r <= nxt_gt;
          lt_r <= nxt_lt;
          sa   <= sa << 2;
          sb   <= sb << 2;
          cnt  <= cnt - CNT_W'(1);
          if (finish) begin
            // The outputs are loaded from the next-state accumulators. They
            // therefore include the pair that was compared in this cycle.
            out_valid <= 1'b1;
            gt        <= nxt_gt;
            lt        <= nxt_lt;
            et        <= ~nxt_gt & ~nxt_lt;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            gt        <= 1'b0;
            et        <= 1'b0;
            lt        <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          gt        <= 1'b0;
          et        <= 1'b0;
          lt        <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_magnitude_comparator

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator. It builds three instances:
//   u0: WIDTH=8, EARLY_EXIT=0   u1: WIDTH=8, EARLY_EXIT=1   u2: WIDTH=2
// u0 and u1 receive the same stimulus. Expected results and latencies are
// pushed into per-instance queues. A negedge monitor pops an entry and
// compares it whenever an instance raises out_valid.
module tb_serial_magnitude_comparator;

  typedef struct {
    logic gt;
    logic et;
    logic lt;
    int   lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv  [3];
  logic       ir  [3];
  logic       orr [3];
  logic       ov  [3];
  logic       g   [3];
  logic       e   [3];
  logic       l   [3];
  logic       bz  [3];
  logic [7:0] a_s [3];
  logic [7:0] b_s [3];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb_q [3][$];

  int   acc   [3];
  logic pv_ov [3];
  logic pv_or [3];
  logic pv_g  [3];
  logic pv_e  [3];
  logic pv_l  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .gt(g[0]), .et(e[0]), .lt(l[0]), .busy(bz[0])
  );

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .gt(g[1]), .et(e[1]), .lt(l[1]), .busy(bz[1])
  );

  serial_magnitude_comparator #(.WIDTH(2), .EARLY_EXIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s[2][1:0]), .b(b_s[2][1:0]), .out_valid(ov[2]), .out_ready(orr[2]),
    .gt(g[2]), .et(e[2]), .lt(l[2]), .busy(bz[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares results and latency, checks that outputs stay stable
  // while held, and checks the release after a handshake.
  always @(negedge clk) begin
    exp_t ex;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pv_ov[i] = 1'b0;
        pv_or[i] = 1'b0;
        acc[i]   = -1;
      end else begin
        if (pv_ov[i] && !pv_or[i]) begin
          check($sformatf("hold_valid_u%0d", i), 32'(ov[i]), 32'd1);
          check($sformatf("hold_result_u%0d", i), {29'd0, g[i], e[i], l[i]},
                {29'd0, pv_g[i], pv_e[i], pv_l[i]});
        end
        if (pv_ov[i] && pv_or[i])
          check($sformatf("release_u%0d", i), 32'(ov[i]), 32'd0);
        if (ov[i] && !pv_ov[i]) begin
          if (sb_q[i].size() == 0) begin
            check($sformatf("unexpected_result_u%0d", i), 32'd1, 32'd0);
          end else begin
            ex = sb_q[i].pop_front();
            check($sformatf("result_u%0d", i), {29'd0, g[i], e[i], l[i]},
                  {29'd0, ex.gt, ex.et, ex.lt});
            check($sformatf("latency_u%0d", i), 32'(cyc - acc[i]), 32'(ex.lat));
          end
        end
        if (iv[i] && ir[i]) acc[i] = cyc + 1;
        pv_ov[i] = ov[i];
        pv_or[i] = orr[i];
        pv_g[i]  = g[i];
        pv_e[i]  = e[i];
        pv_l[i]  = l[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      if (ir[0] && ir[1] && ir[2] && !ov[0] && !ov[1] && !ov[2]) return;
      tick();
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input logic eg, input logic ee, input logic el,
                       input int lat0, input int lat1);
    exp_t x0;
    exp_t x1;
    x0 = '{eg, ee, el, lat0};
    x1 = '{eg, ee, el, lat1};
    sb_q[0].push_back(x0);
    sb_q[1].push_back(x1);
    a_s[0] = a; a_s[1] = a;
    b_s[0] = b; b_s[1] = b;
    iv[0] = 1'b1; iv[1] = 1'b1;
    tick();
    iv[0] = 1'b0; iv[1] = 1'b0;
  endtask

  task automatic send2(input logic [1:0] a, input logic [1:0] b,
                       input logic eg, input logic ee, input logic el);
    exp_t x;
    x = '{eg, ee, el, 1};
    sb_q[2].push_back(x);
    a_s[2] = {6'd0, a};
    b_s[2] = {6'd0, b};
    iv[2] = 1'b1;
    tick();
    iv[2] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b1; a_s[i] = '0; b_s[i] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(ir[0]), 32'd1);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_result",    {29'd0, g[0], e[0], l[0]}, 32'd0);
    check("rst_busy",      32'(bz[0]), 32'd0);
    check("rst_in_ready_w2", 32'(ir[2]), 32'd1);

    // Equal, MSB-pair difference, last-pair difference
    send8(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 4, 4);  wait_idle();
    send8(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 4, 1);  wait_idle();
    send8(8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 4, 4);  wait_idle();

    // Result held with out_ready low
    orr[0] = 1'b0; orr[1] = 1'b0;
    send8(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 4, 1);
    for (int n = 0; n < 20 && !ov[0]; n++) tick();
    check("hold_reached_valid", 32'(ov[0]), 32'd1);
    for (int n = 0; n < 3; n++) begin
      check("hold_in_ready_u0", 32'(ir[0]), 32'd0);
      check("hold_in_ready_u1", 32'(ir[1]), 32'd0);
      tick();
    end
    orr[0] = 1'b1; orr[1] = 1'b1;
    wait_idle();

    // Operand and in_valid toggling during RUN must not be captured
    send8(8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, 4, 4);
    for (int n = 0; n < 3; n++) begin
      iv[0] = n[0] ? 1'b0 : 1'b1; iv[1] = iv[0];
      a_s[0] = 8'hFF; a_s[1] = 8'hFF; b_s[0] = 8'h00; b_s[1] = 8'h00;
      check("run_in_ready_u0", 32'(ir[0]), 32'd0);
      check("run_in_ready_u1", 32'(ir[1]), 32'd0);
      check("run_busy_u0",     32'(bz[0]), 32'd1);
      tick();
    end
    iv[0] = 1'b0; iv[1] = 1'b0;
    wait_idle();

    // Reset on the second RUN cycle aborts without a result
    a_s[0] = 8'h55; a_s[1] = 8'h55; b_s[0] = 8'h54; b_s[1] = 8'h54;
    iv[0] = 1'b1; iv[1] = 1'b1;
    tick();
    iv[0] = 1'b0; iv[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready_u0",  32'(ir[0]), 32'd1);
    check("abort_in_ready_u1",  32'(ir[1]), 32'd1);
    check("abort_out_valid_u0", 32'(ov[0]), 32'd0);
    check("abort_busy_u0",      32'(bz[0]), 32'd0);
    repeat (6) tick();
    send8(8'h03, 8'h09, 1'b0, 1'b0, 1'b1, 4, 3);  wait_idle();

    // WIDTH=2 instance
    send2(2'd2, 2'd1, 1'b1, 1'b0, 1'b0);  wait_idle();
    send2(2'd1, 2'd1, 1'b0, 1'b1, 1'b0);  wait_idle();
    send2(2'd0, 2'd3, 1'b0, 1'b0, 1'b1);  wait_idle();

    repeat (4) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("queue_drained_u%0d", i), 32'(sb_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_magnitude_comparator
